// File: rtl/cu_pkg.sv
// Shared types and constants for the processor control unit: FSM states,
// opcode encodings, ALU function codes and instruction field positions.
package cu_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_MV  = 4'b0000,
    OP_MVI = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101
  } opcode_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;

  // ALU function for a two-operand opcode; non-ALU opcodes map to add.
  function automatic logic [1:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_OR:   alu_sel = ALU_OR;
      default: alu_sel = ALU_ADD;
    endcase
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    is_alu_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/dec3to8.sv
// One-hot register decoder: a 3-bit register index plus enable becomes a
// one-hot select vector (all zero when disabled).
module dec3to8 #(
  parameter int NOUT = 8
) (
  input  logic [2:0]      idx,
  input  logic            en,
  output logic [NOUT-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[idx] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 10-bit processor datapath. Falling-edge state
// register; outputs are a combinational decode of state and IR.
module control_unit
  import cu_pkg::*;
#(
  parameter int N    = 10,
  parameter int NREG = 8
) (
  input  logic            CLKb,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [N-1:0]    IR,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic [1:0]      ALUop,
  output logic            Done
);

  state_t     state, state_nxt;
  logic [3:0] op;
  logic [2:0] rx, ry;

  logic       irin_d, dinout_d, ain_d, gin_d, gout_d, done_d;
  logic [1:0] aluop_d;
  logic       rin_en, rout_en;
  logic [2:0] rin_idx, rout_idx;

  assign op = IR[N-1:N-4];
  assign rx = IR[RX_HI:RX_LO];
  assign ry = IR[RY_HI:RY_LO];

  always_ff @(negedge CLKb) begin
    if (!Resetn) state <= T0;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    irin_d    = 1'b0;
    dinout_d  = 1'b0;
    ain_d     = 1'b0;
    gin_d     = 1'b0;
    gout_d    = 1'b0;
    done_d    = 1'b0;
    aluop_d   = ALU_ADD;
    rin_en    = 1'b0;
    rout_en   = 1'b0;
    rin_idx   = rx;
    rout_idx  = rx;
    case (state)
      T0: begin
        // IR and FSM both capture on this edge when Run is high
        irin_d = Run;
        if (Run) state_nxt = T1;
      end
      T1: begin
        if (op == OP_MV) begin
          rout_en   = 1'b1;
          rout_idx  = ry;
          rin_en    = 1'b1;
          done_d    = 1'b1;
          state_nxt = T0;
        end else if (op == OP_MVI) begin
          dinout_d  = 1'b1;
          rin_en    = 1'b1;
          done_d    = 1'b1;
          state_nxt = T0;
        end else if (is_alu_op(op)) begin
          rout_en   = 1'b1;
          ain_d     = 1'b1;
          state_nxt = T2;
        end else begin
          done_d    = 1'b1;
          state_nxt = T0;
        end
      end
      T2: begin
        rout_en   = 1'b1;
        rout_idx  = ry;
        gin_d     = 1'b1;
        aluop_d   = alu_sel(op);
        state_nxt = T3;
      end
      T3: begin
        gout_d    = 1'b1;
        rin_en    = 1'b1;
        done_d    = 1'b1;
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase
  end

  // Reset held low silences every output, including the register decoders.
  dec3to8 #(.NOUT(NREG)) u_rin_dec (
    .idx (rin_idx),
    .en  (rin_en & Resetn),
    .y   (Rin)
  );

  dec3to8 #(.NOUT(NREG)) u_rout_dec (
    .idx (rout_idx),
    .en  (rout_en & Resetn),
    .y   (Rout)
  );

  assign IRin   = irin_d & Resetn;
  assign DINout = dinout_d & Resetn;
  assign Ain    = ain_d & Resetn;
  assign Gin    = gin_d & Resetn;
  assign Gout   = gout_d & Resetn;
  assign Done   = done_d & Resetn;
  assign ALUop  = Resetn ? aluop_d : 2'b00;

endmodule
